// File: rtl/seq_mult_display.sv
// seq_mult_display: WIDTH-cycle shift-add multiplier whose held product is
// scanned onto a multiplexed common-anode seven-segment hex display.
`default_nettype none

module seq_mult_display #(
    parameter int WIDTH   = 8,
    parameter int DIGITS  = 4,
    parameter int REFRESH = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [6:0]           seg,
    output logic [DIGITS-1:0]    an
);

    localparam int PW = 2 * WIDTH;
    localparam int DW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH);
    localparam int RW = (REFRESH > 1) ? $clog2(REFRESH) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [DIGITS-1:0] AN_RESET = ~(DIGITS'(1));

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [PW-1:0]      acc;
    logic [CW-1:0]      count;
    logic [PW-1:0]      partial;
    logic [PW-1:0]      sum;

    assign partial = b_reg[0] ? ({{WIDTH{1'b0}}, a_reg} << count) : '0;
    assign sum     = acc + partial;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            count   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= a;
                        b_reg <= b;
                        acc   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Every bit is visited even once b_reg empties, so latency is fixed.
                    acc   <= sum;
                    b_reg <= b_reg >> 1;
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        product <= sum;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    logic [DW-1:0]      disp_word;
    logic [RW-1:0]      refresh_cnt;
    logic [IW-1:0]      digit_idx;
    logic [3:0]         nibble;
    logic [DIGITS-1:0]  an_next;

    generate
        if (PW >= DW) begin : g_trunc
            assign disp_word = product[DW-1:0];
        end else begin : g_zext
            assign disp_word = {{(DW - PW){1'b0}}, product};
        end
    endgenerate

    always_comb begin
        nibble  = 4'h0;
        an_next = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_idx == IW'(i)) begin
                nibble     = disp_word[4*i +: 4];
                an_next[i] = 1'b0;
            end
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // seg and an are both registered from the same index so digits switch cleanly.
    always_ff @(posedge clk) begin
        if (reset) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            an          <= AN_RESET;
            seg         <= 7'b1000000;
        end else begin
            if (refresh_cnt == RW'(REFRESH - 1)) begin
                refresh_cnt <= '0;
                digit_idx   <= (digit_idx == IW'(DIGITS - 1)) ? '0 : digit_idx + IW'(1);
            end else begin
                refresh_cnt <= refresh_cnt + RW'(1);
            end
            an  <= an_next;
            seg <= hex7(nibble);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_mult_display.sv
// tb_seq_mult_display: directed and random checks of seq_mult_display against
// a cycle-level behavioural model (arithmetic product, cycle-count display scan).
`default_nettype none

module tb_seq_mult_display;

    localparam int WIDTH   = 8;
    localparam int DIGITS  = 4;
    localparam int REFRESH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        start;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [6:0]  seg;
    logic [3:0]  an;

    always #5 clk = ~clk;

    seq_mult_display #(
        .WIDTH   (WIDTH),
        .DIGITS  (DIGITS),
        .REFRESH (REFRESH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .a       (a),
        .b       (b),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .product (product),
        .seg     (seg),
        .an      (an)
    );

    int tests = 0;
    int fails = 0;

    logic [6:0] hex_tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Behavioural model: cycles left in the current job, its result, and
    // the number of clock edges since reset for the display scan.
    int          m_left = 0;
    logic [15:0] m_res  = '0;
    logic [15:0] m_prod = '0;
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    int          m_k    = 0;
    logic [6:0]  m_seg  = 7'b1000000;
    logic [3:0]  m_an   = 4'b1110;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        int          pidx;
        logic [15:0] pprod;
        @(posedge clk);
        if (reset) begin
            m_left = 0;
            m_busy = 1'b0;
            m_done = 1'b0;
            m_prod = '0;
            m_k    = 0;
            m_seg  = 7'b1000000;
            m_an   = 4'b1110;
        end else begin
            pidx  = (m_k / REFRESH) % DIGITS;
            pprod = m_prod;
            m_k++;
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_prod = m_res;
                    m_done = 1'b1;
                    m_busy = 1'b0;
                end
            end else if (start) begin
                m_res  = 16'(a) * 16'(b);
                m_left = WIDTH;
                m_busy = 1'b1;
            end
            m_seg = hex_tbl[pprod[4*pidx +: 4]];
            m_an  = ~(4'b0001 << pidx);
        end
        #1;
        check({tag, ".busy"}, busy, m_busy);
        check({tag, ".done"}, done, m_done);
        check({tag, ".product"}, product, m_prod);
        check({tag, ".an"}, an, m_an);
        check({tag, ".seg"}, seg, m_seg);
    endtask

    task automatic do_mult(input logic [7:0] x, input logic [7:0] y, input string tag);
        a     = x;
        b     = y;
        start = 1'b1;
        step(tag);
        start = 1'b0;
        repeat (WIDTH) step(tag);
        check({tag, ".final_done"}, done, 1'b1);
        check({tag, ".final_product"}, product, 16'(x) * 16'(y));
        step(tag);
    endtask

    initial begin
        int ndone;
        int guard;

        reset = 1'b1;
        start = 1'b1;
        a     = 8'd5;
        b     = 8'd7;
        step("reset");
        step("reset");
        check("reset.busy_c", busy, 1'b0);
        check("reset.product_c", product, 16'h0000);
        check("reset.an_c", an, 4'b1110);
        check("reset.seg_c", seg, 7'b1000000);
        reset = 1'b0;
        start = 1'b0;
        step("post_reset");
        check("post_reset.no_op", busy, 1'b0);

        do_mult(8'd13, 8'd11, "basic");
        check("basic.const", product, 16'h008F);
        do_mult(8'd255, 8'd255, "max");
        check("max.const", product, 16'hFE01);
        do_mult(8'd0, 8'd200, "zero");
        check("zero.const", product, 16'h0000);
        do_mult(8'd1, 8'd1, "one");
        check("one.const", product, 16'h0001);

        // Start and operand changes mid-run must be ignored; start in the done cycle is taken.
        ndone = 0;
        a = 8'd3; b = 8'd5; start = 1'b1;
        step("hs");
        start = 1'b0;
        repeat (3) begin step("hs"); ndone += int'(done); end
        a = 8'd7; b = 8'd9; start = 1'b1;
        step("hs"); ndone += int'(done);
        start = 1'b0; a = 8'd200; b = 8'd100;
        repeat (4) begin step("hs"); ndone += int'(done); end
        check("hs.first_product", product, 16'd15);
        check("hs.done_pulses", ndone, 1);
        a = 8'd7; b = 8'd9; start = 1'b1;
        step("hs2");
        start = 1'b0;
        repeat (WIDTH) step("hs2");
        check("hs2.done", done, 1'b1);
        check("hs2.product", product, 16'd63);
        step("hs2");

        a = 8'd100; b = 8'd100; start = 1'b1;
        step("abort");
        start = 1'b0;
        repeat (3) step("abort");
        reset = 1'b1;
        step("abort");
        check("abort.busy", busy, 1'b0);
        check("abort.product", product, 16'h0000);
        reset = 1'b0;
        ndone = 0;
        repeat (10) begin step("abort_idle"); ndone += int'(done); end
        check("abort.no_done", ndone, 0);
        do_mult(8'd100, 8'd100, "after_abort");
        check("after_abort.const", product, 16'h2710);

        for (int i = 0; i < 40; i++) begin
            a     = 8'($urandom);
            b     = 8'($urandom);
            start = 1'($urandom_range(0, 1));
            step("rand");
        end
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            step("b2b");
        end
        start = 1'b0;
        repeat (WIDTH + 2) step("drain");

        do_mult(8'd255, 8'd255, "disp");
        guard = 0;
        while (an !== 4'b0111 && guard < 20) begin step("disp_seek"); guard++; end
        check("disp.found_digit3", guard < 20, 1'b1);
        check("disp.digit3_seg", seg, 7'b0001110);
        repeat (REFRESH) step("disp_scan");
        check("disp.wrap_an", an, 4'b1110);
        check("disp.digit0_seg", seg, 7'b1111001);
        repeat (DIGITS * REFRESH + 3) step("disp_scan");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
